// File: rtl/spi_frame_buffer_pkg.sv
// Shared definitions for the SPI frame buffer and its neighbours:
// default geometry and the per-cycle operation encoding.
package spi_frame_buffer_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_BUF_SIZE   = 6;
  localparam int DEF_ADDR_WIDTH = 3;

  // {write accepted, read performed} in one cycle
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_BOTH = 2'b11
  } op_t;

endpackage

// File: rtl/spi_edge_detect.sv
// Rising-edge detector. The history register resets to 1 so a level that is
// already high when reset releases is not mistaken for a new edge.
module spi_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  // history register, updated every non-reset cycle
  always_ff @(posedge clk) begin
    if (rst) sig_q <= 1'b1;
    else     sig_q <= sig;
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/spi_frame_buffer.sv
// Multi-word FIFO between the SPI deserialiser and the processing unit.
// One word is stored per rising edge of wr_ready; words drain in order via
// rd_en with one cycle of latency. Sticky overflow/underflow flags.
module spi_frame_buffer
  import spi_frame_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BUF_SIZE   = DEF_BUF_SIZE,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [ADDR_WIDTH-1:0] count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(BUF_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] FULL_CNT = ADDR_WIDTH'(BUF_SIZE);

  logic [DATA_WIDTH-1:0] mem [0:BUF_SIZE-1];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  we;
  logic                  rd_ok;
  logic                  wr_ok;
  logic                  wr_drop;
  op_t                   op;

  // Depth need not be a power of two, so wrap explicitly at the last slot.
  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  spi_edge_detect u_wr_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (wr_ready),
    .rise (we)
  );

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // A read in the same cycle frees a slot, so a write into a full buffer is
  // still accepted. An empty buffer never bypasses the write to the reader.
  assign rd_ok   = rd_en & ~empty;
  assign wr_ok   = we & (~full | rd_ok);
  assign wr_drop = we & full & ~rd_en;

  // classify the cycle for the occupancy update
  always_comb begin
    op = op_t'({wr_ok, rd_ok});
  end

  // storage array: no reset, contents are don't-care after reset/clear
  always_ff @(posedge clk) begin
    if (!rst && !clear && wr_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // pointers, occupancy, read register and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (rd_ok) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= ptr_inc(rd_ptr);
      end
      data_valid <= rd_ok;
      case (op)
        OP_WR:   count <= count + 1'b1;
        OP_RD:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_drop) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_buffer.sv
// Scoreboard bench for spi_frame_buffer: stimulus queues expected read data
// and expected status snapshots; a negedge monitor pops and compares.
module tb_spi_frame_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       wr_ready;
  logic [7:0] data_in;
  logic       rd_en;
  logic [7:0] data_out;
  logic       data_valid;
  logic [2:0] count;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       underflow;

  typedef struct {
    bit       chk_st;
    int       cnt;
    bit       emp;
    bit       ful;
    bit       ov;
    bit       un;
    bit       vld;
    bit       chk_dout;
    int       dout;
    bit       chk_drain;
  } st_t;

  int  data_q[$];
  st_t st_q[$];
  int  checks = 0;
  int  errors = 0;

  spi_frame_buffer #(.DATA_WIDTH(8), .BUF_SIZE(6), .ADDR_WIDTH(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .wr_ready   (wr_ready),
    .data_in    (data_in),
    .rd_en      (rd_en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  // ---------------- monitor ----------------
  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin
    st_t s;
    int  d;
    forever begin
      @(negedge clk);
      if (data_valid === 1'b1) begin
        if (data_q.size() == 0) begin
          cmp("unexpected_valid", 1, 0);
        end else begin
          d = data_q.pop_front();
          cmp("read_data", int'(data_out), d);
        end
      end
      while (st_q.size() > 0) begin
        s = st_q.pop_front();
        if (s.chk_st) begin
          cmp("count",      int'(count),      s.cnt);
          cmp("empty",      int'(empty),      int'(s.emp));
          cmp("full",       int'(full),       int'(s.ful));
          cmp("overflow",   int'(overflow),   int'(s.ov));
          cmp("underflow",  int'(underflow),  int'(s.un));
          cmp("data_valid", int'(data_valid), int'(s.vld));
        end
        if (s.chk_dout) cmp("data_out_hold", int'(data_out), s.dout);
        if (s.chk_drain) cmp("pending_reads", data_q.size(), 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input int cnt, input bit emp, input bit ful,
                           input bit ov, input bit un, input bit vld);
    st_t s;
    s = '{chk_st: 1'b1, cnt: cnt, emp: emp, ful: ful, ov: ov, un: un, vld: vld,
          chk_dout: 1'b0, dout: 0, chk_drain: 1'b0};
    st_q.push_back(s);
  endtask

  task automatic expect_dout(input int d);
    st_t s;
    s = '{chk_st: 1'b0, cnt: 0, emp: 1'b0, ful: 1'b0, ov: 1'b0, un: 1'b0, vld: 1'b0,
          chk_dout: 1'b1, dout: d, chk_drain: 1'b0};
    st_q.push_back(s);
  endtask

  task automatic wr(input int d);
    wr_ready = 1'b1;
    data_in  = 8'(d);
    step();
    wr_ready = 1'b0;
    step();
  endtask

  task automatic rd(input int d);
    data_q.push_back(d);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    st_t s;
    int  budget;
    rst = 1'b1; clear = 1'b0; wr_ready = 1'b0; data_in = '0; rd_en = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    expect_st(0, 1, 0, 0, 0, 0);
    expect_dout(0);

    // 1: held level stores once; one-cycle read latency
    wr_ready = 1'b1; data_in = 8'd2;
    step(); step();
    wr_ready = 1'b0;
    step();
    expect_st(1, 0, 0, 0, 0, 0);
    rd(2);
    expect_st(0, 1, 0, 0, 0, 1);
    step();

    // 2: fill, overflow, drain in order
    for (int i = 2; i <= 7; i++) begin
      wr(i);
      expect_st(i - 1, 0, (i == 7), 0, 0, 0);
    end
    wr(8);
    expect_st(6, 0, 1, 1, 0, 0);
    for (int i = 2; i <= 7; i++) begin
      rd(i);
      expect_st(7 - i, (i == 7), 0, 1, 0, 1);
    end
    step();
    do_clear();
    expect_st(0, 1, 0, 0, 0, 0);

    // 3: pointer wrap at BUF_SIZE
    for (int i = 0; i < 6; i++) begin
      wr(10 + i);
      expect_st(i + 1, 0, (i == 5), 0, 0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      rd(10 + i);
      expect_st(5 - i, 0, 0, 0, 0, 1);
    end
    for (int i = 0; i < 3; i++) begin
      wr(16 + i);
      expect_st(3 + i, 0, 0, 0, 0, 0);
    end
    for (int i = 0; i < 5; i++) begin
      rd(14 + i);
      expect_st(4 - i, (i == 4), 0, 0, 0, 1);
    end
    step();

    // 4: full + write + read in the same cycle
    for (int i = 0; i < 6; i++) wr(20 + i);
    expect_st(6, 0, 1, 0, 0, 0);
    data_q.push_back(20);
    wr_ready = 1'b1; data_in = 8'd9; rd_en = 1'b1;
    step();
    wr_ready = 1'b0; rd_en = 1'b0;
    expect_st(6, 0, 1, 0, 0, 1);
    step();
    for (int i = 21; i <= 25; i++) rd(i);
    rd(9);
    expect_st(0, 1, 0, 0, 0, 1);
    step();

    // 5: underflow holds data_out; clear resets flags
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    expect_st(0, 1, 0, 0, 1, 0);
    expect_dout(9);
    do_clear();
    expect_st(0, 1, 0, 0, 0, 0);
    expect_dout(9);

    // empty + write + read: underflow, write stored, no bypass
    wr_ready = 1'b1; data_in = 8'd30; rd_en = 1'b1;
    step();
    wr_ready = 1'b0; rd_en = 1'b0;
    expect_st(1, 0, 0, 0, 1, 0);
    step();
    rd(30);
    expect_st(0, 1, 0, 0, 1, 1);
    do_clear();

    // edge coinciding with clear is lost and does not retrigger
    wr_ready = 1'b1; data_in = 8'd50; clear = 1'b1;
    step();
    clear = 1'b0;
    expect_st(0, 1, 0, 0, 0, 0);
    step();
    expect_st(0, 1, 0, 0, 0, 0);
    wr_ready = 1'b0;
    step();

    // 6: reset mid-burst with wr_ready held high through release
    wr(60); wr(61); wr(62);
    expect_st(3, 0, 0, 0, 0, 0);
    rd(60);
    wr_ready = 1'b1; data_in = 8'd70;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step(); step();
    expect_st(0, 1, 0, 0, 0, 0);
    expect_dout(0);
    wr_ready = 1'b0;
    step();
    expect_st(0, 1, 0, 0, 0, 0);
    wr(63);
    expect_st(1, 0, 0, 0, 0, 0);
    rd(63);
    expect_st(0, 1, 0, 0, 0, 1);
    step(); step();

    s = '{chk_st: 1'b0, cnt: 0, emp: 1'b0, ful: 1'b0, ov: 1'b0, un: 1'b0, vld: 1'b0,
          chk_dout: 1'b0, dout: 0, chk_drain: 1'b1};
    st_q.push_back(s);
    budget = 0;
    while (st_q.size() > 0 && budget < 20) begin
      step();
      budget++;
    end
    if (st_q.size() > 0) begin
      errors++;
      $display("FAIL monitor_timeout actual=%0d required=0", st_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
